reg_wb_arbiter: RTL

Write-port arbiter and scoreboard for the 32x32 register file in the ID stage. Two writeback sources share the file's single write port: the ALU result path (requester 0) and the load-data path (requester 1). The block grants one of them per cycle round-robin and drives the register file's write address, data and write-enable from a registered output stage. It also keeps a per-register busy scoreboard that ID uses to stall on pending writes.

---
 rtl/rf_pkg.sv | 18 +
 rtl/rr_arb2.sv | 36 +++
 rtl/reg_wb_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared register-file definitions: widths, requester indices, writeback request payload.
package rf_pkg;

  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NREG    = 1 << ADDR_W;

  // Requester indices on the shared write port
  localparam int unsigned REQ_ALU = 0;
  localparam int unsigned REQ_LD  = 1;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   req[1:0]   : request lines
//   gnt[1:0]   : grant, one-hot or zero, combinational from req and the priority flop
// The priority flop names the winner under contention and toggles only when
// both requests are present; a lone requester wins without disturbing it.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic r_prio;
  logic w_both;

  assign w_both = req[0] & req[1];

  // Grant: lone requester wins, contention resolved by r_prio
  always_comb begin
    gnt    = 2'b00;
    gnt[0] = req[0] & (~req[1] | ~r_prio);
    gnt[1] = req[1] & (~req[0] |  r_prio);
  end

  // Priority flop: flips after each contended grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= 1'b0;
    end else if (w_both) begin
      r_prio <= ~r_prio;
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Register-file write-port arbiter and pending-write scoreboard.
// Ports:
//   clk, rst_n                     : clock, async active-low reset
//   wb0_valid/addr/data, wb0_ready : ALU writeback request and accept
//   wb1_valid/addr/data, wb1_ready : load writeback request and accept
//   rsv_valid, rsv_addr            : destination reservation from ID
//   reg_wr, reg_write_addr, reg_din: registered register-file write port
//   busy[NREG-1:0]                 : per-register pending-write flags
module reg_wb_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned ADDR_W = rf_pkg::ADDR_W,
  parameter int unsigned DATA_W = rf_pkg::DATA_W,
  parameter int unsigned NREG   = rf_pkg::NREG
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb0_valid,
  input  logic [ADDR_W-1:0] wb0_addr,
  input  logic [DATA_W-1:0] wb0_data,
  output logic              wb0_ready,
  input  logic              wb1_valid,
  input  logic [ADDR_W-1:0] wb1_addr,
  input  logic [DATA_W-1:0] wb1_data,
  output logic              wb1_ready,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              reg_wr,
  output logic [ADDR_W-1:0] reg_write_addr,
  output logic [DATA_W-1:0] reg_din,
  output logic [NREG-1:0]   busy
);

  wb_req_t           w_req [2];
  logic [1:0]        w_vld;
  logic [1:0]        w_gnt;
  logic              w_xfer;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;
  logic [NREG-1:0]   w_set;
  logic [NREG-1:0]   w_clr;

  logic              r_reg_wr;
  logic [ADDR_W-1:0] r_reg_write_addr;
  logic [DATA_W-1:0] r_reg_din;
  logic [NREG-1:0]   r_busy;

  // Gather requests into the shared payload form
  always_comb begin
    w_req[REQ_ALU] = '{valid: wb0_valid, addr: wb0_addr, data: wb0_data};
    w_req[REQ_LD]  = '{valid: wb1_valid, addr: wb1_addr, data: wb1_data};
    w_vld          = {w_req[REQ_LD].valid, w_req[REQ_ALU].valid};
  end

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (w_vld),
    .gnt   (w_gnt)
  );

  assign wb0_ready = w_gnt[REQ_ALU];
  assign wb1_ready = w_gnt[REQ_LD];
  assign w_xfer    = |w_gnt;

  // Winning payload
  always_comb begin
    w_sel_addr = w_req[REQ_ALU].addr;
    w_sel_data = w_req[REQ_ALU].data;
    if (w_gnt[REQ_LD]) begin
      w_sel_addr = w_req[REQ_LD].addr;
      w_sel_data = w_req[REQ_LD].data;
    end
  end

  // Output stage: r0 writes are accepted and latched but never enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg_wr         <= 1'b0;
      r_reg_write_addr <= '0;
      r_reg_din        <= '0;
    end else begin
      r_reg_wr <= w_xfer && (w_sel_addr != '0);
      if (w_xfer) begin
        r_reg_write_addr <= w_sel_addr;
        r_reg_din        <= w_sel_data;
      end
    end
  end

  // Scoreboard set/clear masks; index 0 is left out so busy[0] stays 0
  always_comb begin
    w_set = '0;
    w_clr = '0;
    for (int unsigned i = 1; i < NREG; i++) begin
      w_set[i] = rsv_valid && (rsv_addr == ADDR_W'(i));
      w_clr[i] = r_reg_wr && (r_reg_write_addr == ADDR_W'(i));
    end
  end

  // Set applied after clear so a new reservation wins over a retiring write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_set;
    end
  end

  assign reg_wr         = r_reg_wr;
  assign reg_write_addr = r_reg_write_addr;
  assign reg_din        = r_reg_din;
  assign busy           = r_busy;

endmodule
